// File: rtl/player_phase.sv
// player_phase: responder for the game-state phase handshake.
// Runs the action-selection phase when state_in matches PHASE_CODE. The cursor
// moves over a row of action boxes and a confirm animation plays before the
// block reports completion. The menu is rendered as a registered RGB444 stream.
// Optional feature: define PLAYER_PHASE_TIMEOUT_EN to auto-confirm in SELECT
// after TIMEOUT_FRAMES frame starts with no rotate/confirm activity.
module player_phase #(
    parameter logic [3:0]  PHASE_CODE     = 4'b0001,
    parameter int unsigned NUM_OPTIONS    = 4,
    parameter int unsigned ANIM_FRAMES    = 30,
    parameter int unsigned TIMEOUT_FRAMES = 600,
    parameter int unsigned BOX_X0         = 128,
    parameter int unsigned BOX_Y          = 600,
    parameter int unsigned BOX_W          = 160,
    parameter int unsigned BOX_H          = 96,
    parameter int unsigned BOX_GAP        = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [3:0]  state_in,
    input  logic [3:0]  turn_in,
    input  logic [1:0]  rotate_in,
    input  logic        confirm_in,
    output logic        busy_out,
    output logic        finished_out,
    output logic [2:0]  action_out,
    output logic [11:0] pixel_out
);

    localparam int unsigned PITCH   = BOX_W + BOX_GAP;
    localparam int unsigned CNT_MAX = (ANIM_FRAMES > TIMEOUT_FRAMES) ? ANIM_FRAMES : TIMEOUT_FRAMES;
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) < 3) ? 3 : $clog2(CNT_MAX + 1);
    localparam logic [2:0]  LAST    = 3'(NUM_OPTIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ANIM,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [3:0]         prev_code_q;
    logic [2:0]         cursor_q;
    logic               turn0_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               finished_q;
    logic [2:0]         action_q;
    logic [11:0]        pixel_q;
    logic [11:0]        pixel_d;

    logic               phase_on;
    logic               start;
    logic               frame_start;
    logic               timeout_hit;
    logic               take;
    logic               unused_turn;

    assign phase_on    = (state_in == PHASE_CODE);
    assign start       = phase_on && (prev_code_q != PHASE_CODE);
    assign frame_start = (hcount_in == '0) && (vcount_in == '0);
    assign unused_turn = ^turn_in[3:1];

`ifdef PLAYER_PHASE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
    logic rot_pulse;
    assign rot_pulse   = (rotate_in == 2'b01) || (rotate_in == 2'b10);
    assign timeout_hit = frame_start && !rot_pulse && !confirm_in && (cnt_q == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // A timeout is handled exactly like a confirm strobe with the current cursor.
    assign take = confirm_in || timeout_hit;

    // Phase state machine with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            prev_code_q <= 4'b0000;
            cursor_q    <= '0;
            turn0_q     <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            action_q    <= '0;
        end else begin
            prev_code_q <= state_in;
            finished_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_SELECT;
                        cursor_q <= '0;
                        turn0_q  <= turn_in[0];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (!phase_on) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (take) begin
                        action_q <= cursor_q;
                        cnt_q    <= '0;
                        state_q  <= S_ANIM;
                    end else begin
                        if (rotate_in == 2'b01) begin
                            cursor_q <= (cursor_q == LAST) ? 3'd0 : cursor_q + 3'd1;
                        end else if (rotate_in == 2'b10) begin
                            cursor_q <= (cursor_q == 3'd0) ? LAST : cursor_q - 3'd1;
                        end
`ifdef PLAYER_PHASE_TIMEOUT_EN
                        if (rot_pulse) begin
                            cnt_q <= '0;
                        end else if (frame_start) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
                S_ANIM: begin
                    if (!phase_on) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (frame_start) begin
                        if (cnt_q == CNT_W'(ANIM_FRAMES - 1)) begin
                            state_q    <= S_DONE;
                            busy_q     <= 1'b0;
                            finished_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic        in_row;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [15:0] left;
    logic [11:0] highlight;

    // Box hit test against the current scan position and colour selection.
    always_comb begin
        in_row  = ({6'd0, vcount_in} >= 16'(BOX_Y)) && ({6'd0, vcount_in} < 16'(BOX_Y + BOX_H));
        hit     = 1'b0;
        hit_idx = '0;
        left    = '0;
        for (int unsigned i = 0; i < NUM_OPTIONS; i++) begin
            left = 16'(BOX_X0 + i * PITCH);
            if (({5'd0, hcount_in} >= left) && ({5'd0, hcount_in} < left + 16'(BOX_W))) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
        hit       = hit && in_row;
        highlight = turn0_q ? 12'h0FF : 12'hFF0;
        pixel_d   = '0;
        if (hit) begin
            case (state_q)
                S_SELECT: pixel_d = (hit_idx == cursor_q) ? highlight : 12'h888;
                S_ANIM:   pixel_d = (hit_idx == action_q) ? (cnt_q[2] ? 12'h888 : highlight) : 12'h444;
                default:  pixel_d = '0;
            endcase
        end
    end

    // One-cycle pixel pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign busy_out     = busy_q;
    assign finished_out = finished_q;
    assign action_out   = action_q;
    assign pixel_out    = pixel_q;

endmodule

// File: tb/tb_player_phase.sv
// tb_player_phase: directed and randomized bench for player_phase, compared
// every cycle against a behavioural model of the phase rules.
module tb_player_phase;

    localparam logic [3:0] PC = 4'b0001;
    localparam int N   = 4;
    localparam int AF  = 30;
    localparam int X0  = 128;
    localparam int BY  = 600;
    localparam int W   = 160;
    localparam int BH  = 96;
    localparam int G   = 32;
`ifdef PLAYER_PHASE_TIMEOUT_EN
    localparam int TOF = 4;
`else
    localparam int TOF = 600;
`endif
    localparam int MI = 0, MS = 1, MA = 2, MD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = 11'd1;
    logic [9:0]  vcount = 10'd1;
    logic [3:0]  state_in = 4'd0;
    logic [3:0]  turn_in = 4'd0;
    logic [1:0]  rotate_in = 2'd0;
    logic        confirm_in = 1'b0;
    logic        busy_out;
    logic        finished_out;
    logic [2:0]  action_out;
    logic [11:0] pixel_out;

    player_phase #(
        .PHASE_CODE(PC),
        .NUM_OPTIONS(N),
        .ANIM_FRAMES(AF),
        .TIMEOUT_FRAMES(TOF),
        .BOX_X0(X0),
        .BOX_Y(BY),
        .BOX_W(W),
        .BOX_H(BH),
        .BOX_GAP(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hcount_in(hcount),
        .vcount_in(vcount),
        .state_in(state_in),
        .turn_in(turn_in),
        .rotate_in(rotate_in),
        .confirm_in(confirm_in),
        .busy_out(busy_out),
        .finished_out(finished_out),
        .action_out(action_out),
        .pixel_out(pixel_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model
    int m_st, m_cur, m_t0, m_cnt, m_act;
    logic [3:0]  m_prev;
    logic [11:0] m_pix;
`ifdef PLAYER_PHASE_TIMEOUT_EN
    int m_idle;
`endif

    function automatic logic [11:0] colour(int st, int cur, int t0, int cnt, int act, int h, int v);
        int d, idx;
        logic [11:0] hl;
        hl = t0 ? 12'h0FF : 12'hFF0;
        if (st != MS && st != MA) return 12'h000;
        if (v < BY || v >= BY + BH || h < X0) return 12'h000;
        d   = h - X0;
        idx = d / (W + G);
        if (idx >= N || (d % (W + G)) >= W) return 12'h000;
        if (st == MS) return (idx == cur) ? hl : 12'h888;
        if (idx != act) return 12'h444;
        return ((cnt / 4) % 2 == 1) ? 12'h888 : hl;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = MI; m_prev = 4'd0; m_cur = 0; m_t0 = 0; m_cnt = 0; m_act = 0; m_pix = 12'h000;
`ifdef PLAYER_PHASE_TIMEOUT_EN
            m_idle = 0;
`endif
        end else begin
            bit on, st_ev, fs, take;
            m_pix = colour(m_st, m_cur, m_t0, m_cnt, m_act, int'(hcount), int'(vcount));
            on    = (state_in == PC);
            st_ev = on && (m_prev != PC);
            m_prev = state_in;
            fs = (hcount == 0) && (vcount == 0);
            case (m_st)
                MI: if (st_ev) begin
                    m_st = MS; m_cur = 0; m_t0 = int'(turn_in[0]); m_cnt = 0;
`ifdef PLAYER_PHASE_TIMEOUT_EN
                    m_idle = 0;
`endif
                end
                MS: if (!on) m_st = MI;
                    else begin
                        take = confirm_in;
`ifdef PLAYER_PHASE_TIMEOUT_EN
                        if (rotate_in == 2'b01 || rotate_in == 2'b10 || confirm_in) m_idle = 0;
                        else if (fs) begin
                            m_idle++;
                            if (m_idle == TOF) take = 1;
                        end
`endif
                        if (take) begin m_act = m_cur; m_cnt = 0; m_st = MA; end
                        else if (rotate_in == 2'b01) m_cur = (m_cur + 1) % N;
                        else if (rotate_in == 2'b10) m_cur = (m_cur + N - 1) % N;
                    end
                MA: if (!on) m_st = MI;
                    else if (fs) begin
                        m_cnt++;
                        if (m_cnt == AF) m_st = MD;
                    end
                default: m_st = MI;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy_out}, {31'd0, (m_st == MS || m_st == MA)});
            chk("finished", {31'd0, finished_out}, {31'd0, (m_st == MD)});
            chk("action", {29'd0, action_out}, 32'(m_act));
            chk("pixel", {20'd0, pixel_out}, {20'd0, m_pix});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [11:0] exp);
        hcount = 11'(h);
        vcount = 10'(v);
        tick();
        chk(name, {20'd0, pixel_out}, {20'd0, exp});
    endtask

    task automatic rot(input logic [1:0] r);
        rotate_in = r;
        tick();
        rotate_in = 2'b00;
    endtask

    initial begin
        int h, v, pick;
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_fin", {31'd0, finished_out}, 32'd0);
        chk("rst_action", {29'd0, action_out}, 32'd0);
        chk("rst_pixel", {20'd0, pixel_out}, 32'd0);

        // Release reset with the phase code already held
        state_in = PC; turn_in = 4'd0; hcount = 11'd200; vcount = 10'd620;
        #2 rst = 1'b1;
        tick();
        chk("start_busy", {31'd0, busy_out}, 32'd1);
        tick();
        chk("start_box0", {20'd0, pixel_out}, 32'hFF0);

        // Cursor wrap both ways
        rot(2'b01); rot(2'b01); rot(2'b01);
        probe("cursor3", 780, 620, 12'hFF0);
        probe("box0_other", 200, 620, 12'h888);
        rot(2'b01);
        probe("wrap_up", 200, 620, 12'hFF0);
        rot(2'b10);
        probe("wrap_down", 780, 620, 12'hFF0);
        rot(2'b10);
        probe("cursor2", 600, 620, 12'hFF0);

        // Confirm wins over same-cycle rotate
        confirm_in = 1'b1; rotate_in = 2'b01;
        tick();
        confirm_in = 1'b0; rotate_in = 2'b00;
        chk("conf_action", {29'd0, action_out}, 32'd2);
        chk("conf_busy", {31'd0, busy_out}, 32'd1);
        probe("anim_sel", 600, 620, 12'hFF0);
        probe("anim_other", 200, 620, 12'h444);

        for (int k = 1; k <= AF; k++) begin
            hcount = 11'd0; vcount = 10'd0;
            tick();
            if (k == AF) begin
                chk("done_fin", {31'd0, finished_out}, 32'd1);
                chk("done_busy", {31'd0, busy_out}, 32'd0);
            end
            hcount = 11'd5; vcount = 10'd5;
            tick();
            if (k == AF) chk("fin_pulse_end", {31'd0, finished_out}, 32'd0);
        end

        // Re-entry with turn 1, render check, then abort during ANIM
        state_in = 4'd0; tick();
        state_in = PC; turn_in = 4'd1; tick();
        rot(2'b01);
        probe("render_box1", 400, 650, 12'h0FF);
        probe("render_gap", 100, 650, 12'h000);
        confirm_in = 1'b1; tick(); confirm_in = 1'b0;
        chk("abort_action", {29'd0, action_out}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            hcount = 11'd0; vcount = 10'd0; tick();
            hcount = 11'd5; vcount = 10'd5; tick();
        end
        hcount = 11'd400; vcount = 10'd650; tick();
        state_in = 4'b1000;
        tick();
        chk("abort_busy", {31'd0, busy_out}, 32'd0);
        chk("abort_fin", {31'd0, finished_out}, 32'd0);
        tick();
        chk("abort_pixel", {20'd0, pixel_out}, 32'd0);
        chk("abort_hold", {29'd0, action_out}, 32'd1);

        // Randomized phase traffic
        for (int c = 0; c < 8000; c++) begin
            if (state_in == PC) begin
                if ((m_st == MI) ? ($urandom % 10 == 0) : ($urandom % 400 == 0))
                    state_in = 4'($urandom_range(2, 15));
            end else if ($urandom % 3 == 0) begin
                state_in = PC;
            end else begin
                state_in = 4'($urandom_range(2, 15));
            end
            turn_in    = 4'($urandom);
            rotate_in  = ($urandom % 5 == 0) ? 2'($urandom) : 2'b00;
            confirm_in = ($urandom % 20 == 0);
            pick = int'($urandom % 10);
            if (pick < 2) begin
                h = 0; v = 0;
            end else if (pick < 5) begin
                h = X0 + int'($urandom % N) * (W + G);
                case ($urandom % 4)
                    0: h = h - 1;
                    1: h = h;
                    2: h = h + W - 1;
                    default: h = h + W;
                endcase
                case ($urandom % 4)
                    0: v = BY - 1;
                    1: v = BY;
                    2: v = BY + BH - 1;
                    default: v = BY + BH;
                endcase
            end else begin
                h = int'($urandom_range(1, 2047));
                v = int'($urandom_range(560, 720));
            end
            hcount = 11'(h);
            vcount = 10'(v);
            if ($urandom % 800 == 0) begin
                #2 rst = 1'b0;
                tick();
                tick();
                #2 rst = 1'b1;
                @(negedge clk);
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
